alu_issue_unit: RTL and testbench

Front end that drives the 32-bit negedge ALU: accepts RV32 integer instructions over a valid/ready handshake, decodes them to the ALU opcode set, reads operands from an internal 32×32 register file, and issues exactly one ALU operation per instruction. It captures the ALU result and writes it back to the register file, and presents a one-cycle writeback report. It sits between instruction fetch and the ALU, and is the producer side of the ALU's enable/operand/opcode interface.

---
 rtl/alu_issue_unit.sv | 107 ++++++++++
 tb/tb_alu_issue_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: decodes RV32 R/I-type ALU instructions, issues one op to the
// negedge ALU, and writes the captured result back to a 32x32 register file.
module alu_issue_unit #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic            alu_enable,
    output logic [XLEN-1:0] alu_opA,
    output logic [XLEN-1:0] alu_opB,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);
    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
    state_t          state;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] rf [NREGS];
    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic [4:0]      rs1, rs2, rd;
    logic            r_type, i_type, is_shift, legal;
    logic [3:0]      op_d;
    logic [XLEN-1:0] a_d, b_raw, b_d;

    assign instr_ready = (state == IDLE);
    assign dbg_data    = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

    always_comb begin
        opc      = instr_q[6:0];
        f3       = instr_q[14:12];
        f7       = instr_q[31:25];
        rs1      = instr_q[19:15];
        rs2      = instr_q[24:20];
        rd       = instr_q[11:7];
        r_type   = (opc == 7'b0110011);
        i_type   = (opc == 7'b0010011);
        is_shift = (f3 == 3'b001) || (f3 == 3'b101);
        // funct3 010/011 are slt/sltu, unsupported; only add has a funct7 variant (sub)
        legal    = r_type ? ((f7 == 7'd0) ? (f3 != 3'b010 && f3 != 3'b011)
                                          : (f7 == 7'b0100000 && f3 == 3'b000))
                 : i_type ? ((f3 != 3'b010 && f3 != 3'b011) && (!is_shift || f7 == 7'd0))
                 : 1'b0;
        op_d     = (f3 == 3'b000) ? {3'b000, r_type & f7[5]}
                 : (f3 == 3'b111) ? 4'd2
                 : (f3 == 3'b110) ? 4'd3
                 : (f3 == 3'b100) ? 4'd4
                 : (f3 == 3'b001) ? 4'd5 : 4'd6;
        a_d      = (rs1 == 5'd0) ? '0 : rf[rs1];
        b_raw    = r_type ? ((rs2 == 5'd0) ? '0 : rf[rs2])
                          : {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
        b_d      = is_shift ? {{(XLEN-5){1'b0}}, b_raw[4:0]} : b_raw;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            instr_q    <= '0;
            alu_enable <= 1'b0;
            alu_opA    <= '0;
            alu_opB    <= '0;
            alu_op     <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            illegal    <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            illegal  <= 1'b0;
            wb_valid <= 1'b0;
            case (state)
                IDLE: if (instr_valid) begin
                    instr_q <= instr;
                    state   <= DECODE;
                end
                DECODE: if (legal) begin
                    alu_opA    <= a_d;
                    alu_opB    <= b_d;
                    alu_op     <= op_d;
                    alu_enable <= 1'b1;
                    state      <= EXEC;
                end else begin
                    illegal <= 1'b1;
                    state   <= IDLE;
                end
                EXEC: begin
                    alu_enable <= 1'b0;
                    wb_valid   <= 1'b1;
                    wb_rd      <= rd;
                    wb_data    <= alu_result;
                    if (rd != 5'd0) rf[rd] <= alu_result;
                    state      <= WB;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: directed + random instructions against an ISA-level model,
// with a simple negedge ALU attached to the issue interface.
module tb_alu_issue_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic        alu_enable;
    logic [31:0] alu_opA, alu_opB;
    logic [3:0]  alu_op;
    logic [31:0] alu_result = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int checks = 0;
    int failures = 0;
    logic [31:0] mregs [32];

    alu_issue_unit dut (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_enable(alu_enable), .alu_opA(alu_opA), .alu_opB(alu_opB),
        .alu_op(alu_op), .alu_result(alu_result), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // negedge ALU attached to the unit
    always @(negedge clk)
        if (alu_enable)
            case (alu_op)
                4'd0: alu_result <= alu_opA + alu_opB;
                4'd1: alu_result <= alu_opA - alu_opB;
                4'd2: alu_result <= alu_opA & alu_opB;
                4'd3: alu_result <= alu_opA | alu_opB;
                4'd4: alu_result <= alu_opA ^ alu_opB;
                4'd5: alu_result <= alu_opA << alu_opB[4:0];
                4'd6: alu_result <= alu_opA >> alu_opB[4:0];
                default: alu_result <= 32'hDEAD_BEEF;
            endcase

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ISA-level meaning of an instruction word
    task automatic ref_model(input logic [31:0] w, output bit legal, output logic [3:0] op,
                             output logic [31:0] a, output logic [31:0] b, output logic [31:0] r);
        logic [31:0] x1, x2, imm;
        bit is_r;
        x1 = mregs[w[19:15]];
        x2 = mregs[w[24:20]];
        imm = {{20{w[31]}}, w[31:20]};
        legal = 1'b1;
        is_r = 1'b1;
        op = 4'd0;
        casez ({w[31:25], w[14:12], w[6:0]})
            17'b0000000_000_0110011: op = 4'd0;
            17'b0100000_000_0110011: op = 4'd1;
            17'b0000000_111_0110011: op = 4'd2;
            17'b0000000_110_0110011: op = 4'd3;
            17'b0000000_100_0110011: op = 4'd4;
            17'b0000000_001_0110011: op = 4'd5;
            17'b0000000_101_0110011: op = 4'd6;
            17'b???????_000_0010011: begin op = 4'd0; is_r = 1'b0; end
            17'b???????_111_0010011: begin op = 4'd2; is_r = 1'b0; end
            17'b???????_110_0010011: begin op = 4'd3; is_r = 1'b0; end
            17'b???????_100_0010011: begin op = 4'd4; is_r = 1'b0; end
            17'b0000000_001_0010011: begin op = 4'd5; is_r = 1'b0; end
            17'b0000000_101_0010011: begin op = 4'd6; is_r = 1'b0; end
            default: legal = 1'b0;
        endcase
        a = x1;
        b = is_r ? x2 : imm;
        if (op >= 4'd5) b = b % 32;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << b;
            default: r = a >> b;
        endcase
    endtask

    task automatic run_instr(input logic [31:0] w);
        bit legal;
        logic [3:0] op;
        logic [31:0] a, b, r;
        logic [4:0] rd;
        int n;
        ref_model(w, legal, op, a, b, r);
        rd = w[11:7];
        n = 0;
        while (!instr_ready && n < 10) begin tick(); n++; end
        check("ready_wait", {31'd0, instr_ready}, 32'd1);
        instr = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr = $urandom;
        check("decode_ready", {31'd0, instr_ready}, 32'd0);
        check("decode_en", {31'd0, alu_enable}, 32'd0);
        tick();
        if (legal) begin
            check("exec_en", {31'd0, alu_enable}, 32'd1);
            check("exec_op", {28'd0, alu_op}, {28'd0, op});
            check("exec_opA", alu_opA, a);
            check("exec_opB", alu_opB, b);
            check("exec_illegal", {31'd0, illegal}, 32'd0);
            tick();
            check("wb_valid", {31'd0, wb_valid}, 32'd1);
            check("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
            check("wb_data", wb_data, r);
            check("wb_en_low", {31'd0, alu_enable}, 32'd0);
            if (rd != 5'd0) mregs[rd] = r;
            dbg_addr = rd;
            #1;
            check("wb_dbg", dbg_data, mregs[rd]);
            tick();
            check("after_wb_valid", {31'd0, wb_valid}, 32'd0);
            check("after_wb_ready", {31'd0, instr_ready}, 32'd1);
        end else begin
            check("ill_pulse", {31'd0, illegal}, 32'd1);
            check("ill_en", {31'd0, alu_enable}, 32'd0);
            check("ill_ready", {31'd0, instr_ready}, 32'd1);
            check("ill_wb", {31'd0, wb_valid}, 32'd0);
            tick();
            check("ill_clear", {31'd0, illegal}, 32'd0);
            check("ill_wb2", {31'd0, wb_valid}, 32'd0);
            check("ill_en2", {31'd0, alu_enable}, 32'd0);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] f7;
        logic [2:0] f3;
        logic [4:0] rs1, rs2, rd;
        logic [11:0] imm;
        int sel;
        sel = $urandom_range(0, 9);
        f3  = 3'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        rd  = 5'($urandom_range(0, 31));
        imm = 12'($urandom);
        f7  = ($urandom_range(0, 3) == 0) ? 7'b0100000 : ($urandom_range(0, 9) == 0 ? 7'h01 : 7'h00);
        if (sel < 4) return {f7, rs2, rs1, f3, rd, 7'b0110011};
        if (sel < 8) begin
            if ((f3 == 3'b001 || f3 == 3'b101) && $urandom_range(0, 3) != 0) imm[11:5] = 7'd0;
            return {imm, rs1, f3, rd, 7'b0010011};
        end
        if (sel == 8) return $urandom;
        return {7'b0100000, rs2, rs1, 3'b101, rd, 7'b0110011};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        // reset held with a handshake offered: must be ignored
        instr_valid = 1'b1;
        instr = 32'h00500093;
        repeat (3) tick();
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_en", {31'd0, alu_enable}, 32'd0);
        check("rst_opA", alu_opA, 32'd0);
        check("rst_opB", alu_opB, 32'd0);
        check("rst_op", {28'd0, alu_op}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            check("rst_dbg", dbg_data, 32'd0);
        end
        instr_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, instr_ready}, 32'd1);

        run_instr(32'h00500093);
        run_instr(32'hFFD00113);
        run_instr(32'h402081B3);
        run_instr(32'h00209233);
        run_instr(32'h00700013);
        run_instr(32'h4020D2B3);
        dbg_addr = 5'd1; #1; check("dir_x1", dbg_data, 32'd5);
        dbg_addr = 5'd2; #1; check("dir_x2", dbg_data, 32'hFFFFFFFD);
        dbg_addr = 5'd3; #1; check("dir_x3", dbg_data, 32'd8);
        dbg_addr = 5'd4; #1; check("dir_x4", dbg_data, 32'hA0000000);
        dbg_addr = 5'd0; #1; check("dir_x0", dbg_data, 32'd0);
        dbg_addr = 5'd5; #1; check("dir_x5", dbg_data, 32'd0);

        for (int k = 0; k < 150; k++) run_instr(rand_instr());

        // reset during EXEC of addi x6,x0,9
        tick();
        instr = 32'h00900313;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("mid_exec_en", {31'd0, alu_enable}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_async_en", {31'd0, alu_enable}, 32'd0);
        check("mid_ready", {31'd0, instr_ready}, 32'd1);
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        repeat (2) begin
            tick();
            check("mid_wb", {31'd0, wb_valid}, 32'd0);
        end
        dbg_addr = 5'd6; #1; check("mid_x6", dbg_data, 32'd0);
        reset_n = 1'b1;
        tick();
        check("mid_post_ready", {31'd0, instr_ready}, 32'd1);
        run_instr(32'h00500093);
        for (int k = 0; k < 20; k++) run_instr(rand_instr());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
